eth_mac_pe_tx_protocol_handle: RTL and testbench
================================================

# eth_mac_pe_tx_protocol_handle

TX protocol engine for the ethernet MAC. It reads 32-bit words from the TX data buffer FIFO (AHB side) and serialises them into a byte stream for the MAC TX framer (preamble/FCS insertion downstream). When enabled, it pads short frames with zero bytes up to the 60-byte minimum. It is the transmit-direction counterpart of the RX protocol handle, and sits between the TX data buffer and the MAC TX byte interface.

## Interface
- PRECACHE_WORDS, 2, depth of the internal word-to-byte precache in 32-bit words (byte depth = 4*PRECACHE_WORDS)
- MIN_FRAME_BYTES, 60, minimum frame length in bytes (DA through payload, FCS excluded) used for padding

- pe_tx_clk  in  1  PE TX clock; the only clock
- pe_tx_rstn  in  1  asynchronous, active-low reset
- txdb_pe2fifo_re  out  1  word read request to the TX data buffer FIFO
- txdb_fifo2pe_rdata  in  32  read word, valid the cycle after txdb_pe2fifo_re
- txdb_fifo_ready  in  1  TX data buffer holds at least one word
- tx_frame_byte_data  out  8  byte to the MAC TX framer
- tx_frame_byte_data_valid  out  1  byte valid
- tx_frame_byte_data_ready  in  1  framer accepts the byte
- tx_frame_byte_data_last  out  1  marks the final byte of the frame (data or pad)
- pe_tx_start  in  1  single-cycle pulse that starts one frame
- pe_tx_logic_clr  in  1  synchronous abort/flush
- tx_handle_done  out  1  single-cycle pulse on frame completion
- r_pad_en  in  1  pad short frames with 0x00
- r_tx_frame_byte_length  in  12  frame bytes held in the buffer (DA..payload, FCS excluded)
- r_tx_frame_byte_real_length  out  12  bytes actually emitted, registered at start

## Operation
- States: IDLE, SEND, PAD, DONE.
- IDLE → SEND on pe_tx_start when length != 0.
  - At that point, latch the length.
  - Set the word count to (len+3)>>2.
  - Set real_length = (r_pad_en && len<60) ? 60 : len.
  - A start with length 0 is ignored, with no done pulse.
  - A start while not in IDLE is ignored.
- Fetch (SEND only): assert txdb_pe2fifo_re for one cycle when all of the following hold:
  - txdb_fifo_ready=1;
  - words remaining > 0;
  - free precache bytes ≥ 4 + 4×(reads in flight).
- The returned word is pushed into the precache little-endian: rdata[7:0] first, rdata[31:24] last.
- For the final word, only the first (len mod 4, 0 meaning 4) bytes are pushed; the remaining bytes are dropped.
- Output in SEND: valid = precache not empty, and data = precache head.
- A byte is transferred when valid && ready. The 12-bit byte counter increments on each transfer.
- SEND → PAD when the last data byte is transferred and real_length > len.
  - In PAD: valid=1 and data=0x00 until the counter reaches real_length.
- last=1 together with valid on the byte whose index is real_length-1.
- After the last byte is transferred, go to DONE. DONE asserts tx_handle_done for 1 cycle, then returns to IDLE.
- pe_tx_logic_clr has priority over everything. The next state is IDLE and:
  - the precache, counters and in-flight tracking are flushed;
  - a read word returning in the following cycle is discarded;
  - there is no done pulse;
  - real_length holds its value.

## Timing
- Reset values: all outputs 0, including tx_frame_byte_data=0x00 and r_tx_frame_byte_real_length=0. State is IDLE.
- Latency from start to first valid is 3 cycles when the FIFO is ready: start → re → data captured → valid.
- Sustained throughput is 1 byte/cycle with ready held high. Reads never exceed 1 per 4 cycles in steady state.
- While valid=1 && ready=0, data and last are held stable.
- valid may drop mid-frame only in SEND, when the precache runs empty (FIFO underflow). It is never withdrawn without a transfer once asserted.
- The precache never overflows: the space check includes in-flight reads.
- The precache never underflows: pops occur only when it is not empty.
- The byte counter never wraps: the maximum len is 4095, and real_length ≤ 4095.
- tx_handle_done is asserted exactly 1 cycle after the last-byte transfer. pe_tx_start is accepted in the cycle after that.
- If pe_tx_start and pe_tx_logic_clr occur together, clr wins and the start is dropped.

## Test plan
- len=64, pad_en=0, FIFO preloaded with 16 words carrying bytes 0x00..0x3F, ready=1:
  - 64 contiguous bytes 0x00..0x3F;
  - last on 0x3F;
  - done 1 cycle later;
  - exactly 16 reads.
- len=42, pad_en=1:
  - 11 reads;
  - 42 data bytes, then 18 bytes of 0x00;
  - last on the 60th byte;
  - real_length=60;
  - bytes 2 and 3 of word 11 are dropped.
- len=42, pad_en=0: 42 bytes, last on byte 42, real_length=42.
- len=64, ready toggling 1/0 every cycle: every byte stays stable while stalled; the sequence and count are unchanged.
- len=16, txdb_fifo_ready low for 10 cycles after word 2: valid drops, then the stream resumes with no loss or duplication.
- pe_tx_logic_clr at byte 20 of a len=64 frame:
  - idle next cycle, valid=0, no done;
  - a following start with len=1 emits exactly one byte with last=1.

Source files
------------

// File: rtl/eth_mac_pe_tx_protocol_handle_if.sv
// TX protocol handle bus bundle: word reads from the TX data buffer FIFO on
// one side, the byte stream towards the MAC TX framer on the other.
// The master modport is the protocol handle; slave is its environment.
interface eth_mac_pe_tx_protocol_handle_if;
  // TX data buffer FIFO side
  logic        txdb_pe2fifo_re;
  logic [31:0] txdb_fifo2pe_rdata;
  logic        txdb_fifo_ready;
  // MAC TX framer byte side
  logic [7:0]  tx_frame_byte_data;
  logic        tx_frame_byte_data_valid;
  logic        tx_frame_byte_data_ready;
  logic        tx_frame_byte_data_last;

  modport master (
    output txdb_pe2fifo_re,
    input  txdb_fifo2pe_rdata,
    input  txdb_fifo_ready,
    output tx_frame_byte_data,
    output tx_frame_byte_data_valid,
    input  tx_frame_byte_data_ready,
    output tx_frame_byte_data_last
  );

  modport slave (
    input  txdb_pe2fifo_re,
    output txdb_fifo2pe_rdata,
    output txdb_fifo_ready,
    input  tx_frame_byte_data,
    input  tx_frame_byte_data_valid,
    output tx_frame_byte_data_ready,
    input  tx_frame_byte_data_last
  );
endinterface

// File: rtl/eth_mac_pe_tx_protocol_handle.sv
// TX protocol engine: fetches 32-bit words from the TX data buffer, unpacks
// them little-endian through a small byte precache and streams bytes to the
// MAC TX framer, optionally zero-padding short frames to the minimum length.
module eth_mac_pe_tx_protocol_handle #(
  parameter int PRECACHE_WORDS  = 2,
  parameter int MIN_FRAME_BYTES = 60
) (
  input  logic                               pe_tx_clk,
  input  logic                               pe_tx_rstn,
  eth_mac_pe_tx_protocol_handle_if.master    tx_bus,
  input  logic                               pe_tx_start,
  input  logic                               pe_tx_logic_clr,
  output logic                               tx_handle_done,
  input  logic                               r_pad_en,
  input  logic [11:0]                        r_tx_frame_byte_length,
  output logic [11:0]                        r_tx_frame_byte_real_length
);

  localparam int          DEPTH   = 4 * PRECACHE_WORDS;
  localparam int          PW      = $clog2(DEPTH);
  localparam int          CW      = $clog2(DEPTH + 1);
  localparam logic [11:0] MIN_LEN = 12'(MIN_FRAME_BYTES);

  typedef enum logic [1:0] {IDLE, SEND, PAD, DONE} state_t;

  state_t          state;
  logic [7:0]      cache [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   fill;
  logic            rd_pending;
  logic [10:0]     words_to_read;
  logic [10:0]     words_to_push;
  logic [11:0]     frame_len;
  logic [11:0]     byte_cnt;

  logic [12:0]     space_need;
  logic            space_ok;
  logic            fetch;
  logic            push;
  logic [2:0]      push_bytes;
  logic            valid;
  logic            xfer;
  logic            pop;

  // Circular pointer advance that also works for non power-of-two depths.
  function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input logic [2:0] k);
    logic [PW:0] s;
    s = {1'b0, p} + (PW+1)'(k);
    if (s >= (PW+1)'(DEPTH)) s = s - (PW+1)'(DEPTH);
    return s[PW-1:0];
  endfunction

  // Fetch/push/pop decisions and the byte-side outputs, decoded from registered state.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    space_need = rd_pending ? 13'd8 : 13'd4;
    space_ok   = (13'(fill) + space_need) <= 13'(DEPTH);
    fetch      = (state == SEND) && tx_bus.txdb_fifo_ready && (words_to_read != 11'd0)
                 && space_ok && !pe_tx_logic_clr;
    push       = rd_pending && (state == SEND) && !pe_tx_logic_clr;
    // Final word carries len mod 4 bytes (0 meaning a full word); the rest is dropped.
    push_bytes = ((words_to_push == 11'd1) && (frame_len[1:0] != 2'b00))
                 ? {1'b0, frame_len[1:0]} : 3'd4;
    valid      = ((state == SEND) && (fill != '0)) || (state == PAD);
    xfer       = valid && tx_bus.tx_frame_byte_data_ready;
    pop        = xfer && (state == SEND);

    tx_bus.txdb_pe2fifo_re          = fetch;
    tx_bus.tx_frame_byte_data_valid = valid;
    tx_bus.tx_frame_byte_data       = ((state == SEND) && (fill != '0)) ? cache[rd_ptr] : 8'h00;
    tx_bus.tx_frame_byte_data_last  = valid && (byte_cnt == r_tx_frame_byte_real_length - 12'd1);
    tx_handle_done                  = (state == DONE);
  end

  // Precache storage: up to four bytes written per returned word, low byte first.
  // NOTE: storage is deliberately not reset; fill and pointers say which entries are live.
  always_ff @(posedge pe_tx_clk) begin
    if (push) begin
      for (int k = 0; k < 4; k++) begin
        if (3'(k) < push_bytes) cache[ptr_add(wr_ptr, 3'(k))] <= tx_bus.txdb_fifo2pe_rdata[8*k +: 8];
      end
    end
  end

  // Frame FSM with precache bookkeeping; clear flushes everything except real_length.
  always_ff @(posedge pe_tx_clk or negedge pe_tx_rstn) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!pe_tx_rstn) begin
      state                       <= IDLE;
      wr_ptr                      <= '0;
      rd_ptr                      <= '0;
      fill                        <= '0;
      rd_pending                  <= 1'b0;
      words_to_read               <= '0;
      words_to_push               <= '0;
      frame_len                   <= '0;
      byte_cnt                    <= '0;
      r_tx_frame_byte_real_length <= '0;
    end else if (pe_tx_logic_clr) begin
      state         <= IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fill          <= '0;
      rd_pending    <= 1'b0;
      words_to_read <= '0;
      words_to_push <= '0;
      byte_cnt      <= '0;
    end else begin
      rd_pending <= fetch;
      if (fetch) words_to_read <= words_to_read - 11'd1;
      if (push) begin
        wr_ptr        <= ptr_add(wr_ptr, push_bytes);
        words_to_push <= words_to_push - 11'd1;
      end
      if (pop) rd_ptr <= ptr_add(rd_ptr, 3'd1);
      fill <= fill + (push ? CW'(push_bytes) : CW'(0)) - CW'(pop);

      case (state)
        IDLE: begin
          if (pe_tx_start && (r_tx_frame_byte_length != 12'd0)) begin
            frame_len     <= r_tx_frame_byte_length;
            words_to_read <= 11'((13'(r_tx_frame_byte_length) + 13'd3) >> 2);
            words_to_push <= 11'((13'(r_tx_frame_byte_length) + 13'd3) >> 2);
            r_tx_frame_byte_real_length <= (r_pad_en && (r_tx_frame_byte_length < MIN_LEN))
                                           ? MIN_LEN : r_tx_frame_byte_length;
            byte_cnt      <= '0;
            state         <= SEND;
          end
        end
        SEND: begin
          if (xfer) begin
            byte_cnt <= byte_cnt + 12'd1;
            if (byte_cnt == frame_len - 12'd1)
              state <= (r_tx_frame_byte_real_length > frame_len) ? PAD : DONE;
          end
        end
        PAD: begin
          if (xfer) begin
            byte_cnt <= byte_cnt + 12'd1;
            if (byte_cnt == r_tx_frame_byte_real_length - 12'd1) state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_mac_pe_tx_protocol_handle.sv
// Bench for the TX protocol handle: FIFO model, byte monitor and a frame-level
// reference model (bytes = little-endian words truncated to len, zero pad to 60).
module tb_eth_mac_pe_tx_protocol_handle;

  logic        clk     = 1'b0;
  logic        rst_n   = 1'b0;
  logic        start   = 1'b0;
  logic        clr     = 1'b0;
  logic        pad_en  = 1'b0;
  logic        done;
  logic [11:0] len_in  = '0;
  logic [11:0] real_len;

  eth_mac_pe_tx_protocol_handle_if tx_bus();

  eth_mac_pe_tx_protocol_handle #(.PRECACHE_WORDS(2), .MIN_FRAME_BYTES(60)) dut (
    .pe_tx_clk                   (clk),
    .pe_tx_rstn                  (rst_n),
    .tx_bus                      (tx_bus),
    .pe_tx_start                 (start),
    .pe_tx_logic_clr             (clr),
    .tx_handle_done              (done),
    .r_pad_en                    (pad_en),
    .r_tx_frame_byte_length      (len_in),
    .r_tx_frame_byte_real_length (real_len)
  );

  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int check_cnt = 0;

  // FIFO model and stimulus state
  logic [31:0] fifo_q[$];
  int reads = 0, hold_at = -1, hold_cnt = 0, fifo_underrun = 0;
  int ready_mode = 0;

  // Captured and expected streams
  logic [7:0] cap_data[$];
  logic       cap_last[$];
  logic [7:0] exp_bytes[$];
  logic       exp_last[$];

  int   cyc = 0, start_cyc = -1, first_valid_cyc = -1, last_cyc = -1, done_cyc = -1;
  int   done_cnt = 0, stab_err = 0, valid_gap = 0;
  bit   frame_active = 0, saw_last = 0, stall_prev = 0;
  logic [7:0] prev_data = '0;
  logic       prev_last = 1'b0;

  // FIFO model: word appears on rdata the cycle after re; optional hold after word hold_at.
  always @(posedge clk) begin
    if (hold_cnt > 0) hold_cnt--;
    if (tx_bus.txdb_pe2fifo_re === 1'b1) begin
      reads++;
      if (fifo_q.size() > 0) tx_bus.txdb_fifo2pe_rdata <= fifo_q.pop_front();
      else fifo_underrun++;
      if (reads == hold_at) hold_cnt = 10;
    end
    tx_bus.txdb_fifo_ready <= (fifo_q.size() > 0) && (hold_cnt == 0);
  end

  // Framer ready pattern, driven on the falling edge.
  always @(negedge clk) begin
    case (ready_mode)
      0:       tx_bus.tx_frame_byte_data_ready = 1'b1;
      1:       tx_bus.tx_frame_byte_data_ready = ~tx_bus.tx_frame_byte_data_ready;
      default: tx_bus.tx_frame_byte_data_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Byte monitor: captures transfers, timing marks and stall-stability violations.
  always @(posedge clk) begin
    cyc++;
    if (start) start_cyc = cyc;
    if (tx_bus.tx_frame_byte_data_valid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (stall_prev) begin
      if (tx_bus.tx_frame_byte_data_valid !== 1'b1 || tx_bus.tx_frame_byte_data !== prev_data ||
          tx_bus.tx_frame_byte_data_last !== prev_last) stab_err++;
    end
    stall_prev = (tx_bus.tx_frame_byte_data_valid === 1'b1) && (tx_bus.tx_frame_byte_data_ready !== 1'b1);
    prev_data  = tx_bus.tx_frame_byte_data;
    prev_last  = tx_bus.tx_frame_byte_data_last;
    if (frame_active && cap_data.size() > 0 && !saw_last && tx_bus.tx_frame_byte_data_valid !== 1'b1)
      valid_gap++;
    if (tx_bus.tx_frame_byte_data_valid === 1'b1 && tx_bus.tx_frame_byte_data_ready === 1'b1) begin
      cap_data.push_back(tx_bus.tx_frame_byte_data);
      cap_last.push_back(tx_bus.tx_frame_byte_data_last);
      if (tx_bus.tx_frame_byte_data_last === 1'b1) begin
        last_cyc = cyc;
        saw_last = 1;
      end
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  // ---------------- stimulus helpers and reference model ----------------

  task automatic clear_expected();
    fifo_q.delete();
    exp_bytes.delete();
    exp_last.delete();
  endtask

  // Queue a frame's words in the FIFO and append its expected byte stream.
  task automatic load_frame(input int n, input bit pad, input bit incr);
    logic [31:0] w;
    int total;
    for (int wi = 0; wi < (n + 3) / 4; wi++) begin
      if (incr) w = {8'(4*wi+3), 8'(4*wi+2), 8'(4*wi+1), 8'(4*wi)};
      else      w = $urandom();
      fifo_q.push_back(w);
      for (int k = 0; k < 4; k++) begin
        if (4*wi + k < n) begin
          exp_bytes.push_back(w[8*k +: 8]);
          exp_last.push_back(1'b0);
        end
      end
    end
    total = n;
    while (pad && total < 60) begin
      exp_bytes.push_back(8'h00);
      exp_last.push_back(1'b0);
      total++;
    end
    exp_last[exp_last.size() - 1] = 1'b1;
  endtask

  task automatic clear_monitor();
    cap_data.delete();
    cap_last.delete();
    reads = 0; done_cnt = 0; stab_err = 0; valid_gap = 0;
    first_valid_cyc = -1; last_cyc = -1; done_cyc = -1; start_cyc = -1;
    saw_last = 0; frame_active = 1;
  endtask

  task automatic pulse_start(input int n, input bit pad);
    len_in = 12'(n);
    pad_en = pad;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
  endtask

  // Returns inside the cycle in which done is high, or ok=0 after the budget.
  task automatic wait_done(output bit ok);
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic settle();
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Number of byte/last disagreements between captured and expected streams.
  function automatic int byte_errors();
    int e;
    int n;
    n = (cap_data.size() < exp_bytes.size()) ? cap_data.size() : exp_bytes.size();
    e = (cap_data.size() > exp_bytes.size()) ? cap_data.size() - exp_bytes.size()
                                             : exp_bytes.size() - cap_data.size();
    for (int i = 0; i < n; i++)
      if (cap_data[i] !== exp_bytes[i] || cap_last[i] !== exp_last[i]) e++;
    return e;
  endfunction

  // ---------------- tests ----------------

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_cnt++; if (tx_bus.txdb_pe2fifo_re !== 1'b0) $display("FAIL reset_re: got %b expected 0", tx_bus.txdb_pe2fifo_re); else pass_cnt++;
    check_cnt++; if (tx_bus.tx_frame_byte_data !== 8'h00) $display("FAIL reset_data: got %h expected 00", tx_bus.tx_frame_byte_data); else pass_cnt++;
    check_cnt++; if (tx_bus.tx_frame_byte_data_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", tx_bus.tx_frame_byte_data_valid); else pass_cnt++;
    check_cnt++; if (tx_bus.tx_frame_byte_data_last !== 1'b0) $display("FAIL reset_last: got %b expected 0", tx_bus.tx_frame_byte_data_last); else pass_cnt++;
    check_cnt++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else pass_cnt++;
    check_cnt++; if (real_len !== 12'd0) $display("FAIL reset_real_length: got %0d expected 0", real_len); else pass_cnt++;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_full_frame();
    bit ok;
    ready_mode = 0;
    clear_expected(); load_frame(64, 0, 1);
    settle(); clear_monitor();
    pulse_start(64, 0);
    wait_done(ok); settle();
    check_cnt++; if (!ok) $display("FAIL full_timeout: got no done, expected done"); else pass_cnt++;
    check_cnt++; if (cap_data.size() != 64) $display("FAIL full_count: got %0d expected 64", cap_data.size()); else pass_cnt++;
    check_cnt++; if (byte_errors() != 0) $display("FAIL full_bytes: got %0d errors expected 0", byte_errors()); else pass_cnt++;
    check_cnt++; if (reads != 16) $display("FAIL full_reads: got %0d expected 16", reads); else pass_cnt++;
    check_cnt++; if (first_valid_cyc - start_cyc != 3) $display("FAIL full_latency: got %0d expected 3", first_valid_cyc - start_cyc); else pass_cnt++;
    check_cnt++; if (last_cyc - first_valid_cyc != 63) $display("FAIL full_throughput: got %0d cycles expected 63", last_cyc - first_valid_cyc); else pass_cnt++;
    check_cnt++; if (done_cyc - last_cyc != 1) $display("FAIL full_done_delay: got %0d expected 1", done_cyc - last_cyc); else pass_cnt++;
    check_cnt++; if (done_cnt != 1) $display("FAIL full_done_count: got %0d expected 1", done_cnt); else pass_cnt++;
    check_cnt++; if (real_len !== 12'd64) $display("FAIL full_real_length: got %0d expected 64", real_len); else pass_cnt++;
  endtask

  task automatic test_pad();
    bit ok;
    ready_mode = 0;
    clear_expected(); load_frame(42, 1, 0);
    settle(); clear_monitor();
    pulse_start(42, 1);
    wait_done(ok); settle();
    check_cnt++; if (!ok) $display("FAIL pad_timeout: got no done, expected done"); else pass_cnt++;
    check_cnt++; if (reads != 11) $display("FAIL pad_reads: got %0d expected 11", reads); else pass_cnt++;
    check_cnt++; if (cap_data.size() != 60) $display("FAIL pad_count: got %0d expected 60", cap_data.size()); else pass_cnt++;
    check_cnt++; if (byte_errors() != 0) $display("FAIL pad_bytes: got %0d errors expected 0", byte_errors()); else pass_cnt++;
    check_cnt++; if (real_len !== 12'd60) $display("FAIL pad_real_length: got %0d expected 60", real_len); else pass_cnt++;
  endtask

  task automatic test_no_pad();
    bit ok;
    ready_mode = 0;
    clear_expected(); load_frame(42, 0, 0);
    settle(); clear_monitor();
    pulse_start(42, 0);
    wait_done(ok); settle();
    check_cnt++; if (!ok) $display("FAIL nopad_timeout: got no done, expected done"); else pass_cnt++;
    check_cnt++; if (cap_data.size() != 42) $display("FAIL nopad_count: got %0d expected 42", cap_data.size()); else pass_cnt++;
    check_cnt++; if (byte_errors() != 0) $display("FAIL nopad_bytes: got %0d errors expected 0", byte_errors()); else pass_cnt++;
    check_cnt++; if (real_len !== 12'd42) $display("FAIL nopad_real_length: got %0d expected 42", real_len); else pass_cnt++;
  endtask

  task automatic test_pad_boundary();
    int lens[4] = '{59, 60, 61, 1};
    bit ok;
    ready_mode = 2;
    foreach (lens[i]) begin
      clear_expected(); load_frame(lens[i], 1, 0);
      settle(); clear_monitor();
      pulse_start(lens[i], 1);
      wait_done(ok); settle();
      check_cnt++; if (!ok || byte_errors() != 0) $display("FAIL boundary_len%0d: got %0d errors (done=%0d) expected 0", lens[i], byte_errors(), ok); else pass_cnt++;
      check_cnt++; if (real_len !== 12'(exp_bytes.size())) $display("FAIL boundary_real_len%0d: got %0d expected %0d", lens[i], real_len, exp_bytes.size()); else pass_cnt++;
    end
  endtask

  task automatic test_stall();
    bit ok;
    ready_mode = 1;
    clear_expected(); load_frame(64, 0, 0);
    settle(); clear_monitor();
    pulse_start(64, 0);
    wait_done(ok); settle();
    check_cnt++; if (!ok) $display("FAIL stall_timeout: got no done, expected done"); else pass_cnt++;
    check_cnt++; if (cap_data.size() != 64) $display("FAIL stall_count: got %0d expected 64", cap_data.size()); else pass_cnt++;
    check_cnt++; if (byte_errors() != 0) $display("FAIL stall_bytes: got %0d errors expected 0", byte_errors()); else pass_cnt++;
    check_cnt++; if (stab_err != 0) $display("FAIL stall_stability: got %0d violations expected 0", stab_err); else pass_cnt++;
    ready_mode = 0;
  endtask

  task automatic test_underflow();
    bit ok;
    ready_mode = 0;
    clear_expected(); load_frame(16, 0, 0);
    settle(); clear_monitor();
    hold_at = 2;
    pulse_start(16, 0);
    wait_done(ok); settle();
    hold_at = -1;
    check_cnt++; if (!ok) $display("FAIL underflow_timeout: got no done, expected done"); else pass_cnt++;
    check_cnt++; if (cap_data.size() != 16) $display("FAIL underflow_count: got %0d expected 16", cap_data.size()); else pass_cnt++;
    check_cnt++; if (byte_errors() != 0) $display("FAIL underflow_bytes: got %0d errors expected 0", byte_errors()); else pass_cnt++;
    check_cnt++; if (valid_gap == 0) $display("FAIL underflow_gap: got %0d idle cycles expected >0", valid_gap); else pass_cnt++;
    check_cnt++; if (reads != 4) $display("FAIL underflow_reads: got %0d expected 4", reads); else pass_cnt++;
  endtask

  task automatic test_clr();
    bit ok;
    ready_mode = 0;
    clear_expected(); load_frame(64, 0, 0);
    settle(); clear_monitor();
    pulse_start(64, 0);
    ok = 0;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #1;
      if (cap_data.size() >= 20) begin
        ok = 1;
        break;
      end
    end
    check_cnt++; if (!ok) $display("FAIL clr_reach20: got %0d bytes expected 20", cap_data.size()); else pass_cnt++;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    check_cnt++; if (tx_bus.tx_frame_byte_data_valid !== 1'b0) $display("FAIL clr_valid: got %b expected 0", tx_bus.tx_frame_byte_data_valid); else pass_cnt++;
    repeat (10) @(posedge clk);
    #1;
    check_cnt++; if (done_cnt != 0) $display("FAIL clr_no_done: got %0d expected 0", done_cnt); else pass_cnt++;
    check_cnt++; if (real_len !== 12'd64) $display("FAIL clr_real_hold: got %0d expected 64", real_len); else pass_cnt++;
    clear_expected(); load_frame(1, 0, 0);
    settle(); clear_monitor();
    pulse_start(1, 0);
    wait_done(ok); settle();
    check_cnt++; if (!ok) $display("FAIL clr_next_timeout: got no done, expected done"); else pass_cnt++;
    check_cnt++; if (cap_data.size() != 1) $display("FAIL clr_next_count: got %0d expected 1", cap_data.size()); else pass_cnt++;
    check_cnt++; if (byte_errors() != 0) $display("FAIL clr_next_byte: got %0d errors expected 0", byte_errors()); else pass_cnt++;
  endtask

  task automatic test_ignored_start();
    bit ok;
    ready_mode = 0;
    // Zero-length start: nothing happens, real_length keeps the previous frame's value (1).
    clear_expected(); settle(); clear_monitor();
    pulse_start(0, 1);
    repeat (10) @(posedge clk);
    #1;
    check_cnt++; if (done_cnt != 0) $display("FAIL zero_len_done: got %0d expected 0", done_cnt); else pass_cnt++;
    check_cnt++; if (reads != 0) $display("FAIL zero_len_reads: got %0d expected 0", reads); else pass_cnt++;
    check_cnt++; if (first_valid_cyc != -1) $display("FAIL zero_len_valid: got valid at %0d expected none", first_valid_cyc); else pass_cnt++;
    check_cnt++; if (real_len !== 12'd1) $display("FAIL zero_len_real: got %0d expected 1", real_len); else pass_cnt++;
    // Start while busy: the running 32-byte frame is unaffected.
    clear_expected(); load_frame(32, 0, 0);
    settle(); clear_monitor();
    pulse_start(32, 0);
    repeat (5) @(posedge clk);
    #1;
    pulse_start(8, 1);
    wait_done(ok); settle();
    check_cnt++; if (!ok || byte_errors() != 0) $display("FAIL busy_start_bytes: got %0d errors (done=%0d) expected 0", byte_errors(), ok); else pass_cnt++;
    check_cnt++; if (real_len !== 12'd32) $display("FAIL busy_start_real: got %0d expected 32", real_len); else pass_cnt++;
    repeat (10) @(posedge clk);
    #1;
    check_cnt++; if (done_cnt != 1) $display("FAIL busy_start_done: got %0d expected 1", done_cnt); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    bit ok_a, ok_b;
    ready_mode = 0;
    clear_expected(); load_frame(10, 0, 0); load_frame(7, 0, 0);
    settle(); clear_monitor();
    pulse_start(10, 0);
    wait_done(ok_a);
    @(posedge clk); #1;
    pulse_start(7, 0);
    wait_done(ok_b); settle();
    check_cnt++; if (!(ok_a && ok_b)) $display("FAIL b2b_timeout: got done=%0d/%0d expected 1/1", ok_a, ok_b); else pass_cnt++;
    check_cnt++; if (byte_errors() != 0) $display("FAIL b2b_bytes: got %0d errors expected 0", byte_errors()); else pass_cnt++;
    check_cnt++; if (done_cnt != 2) $display("FAIL b2b_done_count: got %0d expected 2", done_cnt); else pass_cnt++;
    check_cnt++; if (real_len !== 12'd7) $display("FAIL b2b_real: got %0d expected 7", real_len); else pass_cnt++;
  endtask

  task automatic test_random();
    bit ok;
    int n;
    bit pad;
    ready_mode = 2;
    for (int it = 0; it < 6; it++) begin
      n   = $urandom_range(1, 150);
      pad = 1'($urandom_range(0, 1));
      clear_expected(); load_frame(n, pad, 0);
      settle(); clear_monitor();
      pulse_start(n, pad);
      wait_done(ok); settle();
      check_cnt++; if (!ok || byte_errors() != 0) $display("FAIL random%0d_bytes len=%0d pad=%0d: got %0d errors (done=%0d) expected 0", it, n, pad, byte_errors(), ok); else pass_cnt++;
      check_cnt++; if (real_len !== 12'(exp_bytes.size())) $display("FAIL random%0d_real: got %0d expected %0d", it, real_len, exp_bytes.size()); else pass_cnt++;
      check_cnt++; if (stab_err != 0 || fifo_underrun != 0) $display("FAIL random%0d_protocol: got %0d/%0d violations expected 0/0", it, stab_err, fifo_underrun); else pass_cnt++;
    end
    ready_mode = 0;
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_pad();
    test_no_pad();
    test_pad_boundary();
    test_stall();
    test_underflow();
    test_clr();
    test_ignored_start();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
